// File: rtl/spi_slave.sv
// SPI slave with clk_in-domain oversampling: 2-flop synchronisers plus edge history, 32-bit
// MSB-first shift in/out, modes 0 and 3. rx_data is right-aligned to the number of bits received.
module spi_slave #(
  parameter logic miso_idle = 1'b0
) (
  input  logic        clk_in,
  input  logic        nrst,
  input  logic        spi_sck,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic [31:0] rx_data,
  output logic [5:0]  rx_nbits,
  output logic        rx_valid,
  output logic        busy
);
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_h_q, sck_h_d;
  logic        csn_s1_q, csn_s1_d, csn_s2_q, csn_s2_d, csn_h_q, csn_h_d;
  logic        mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic        settle_q, settle_d, armed_q, armed_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, tx_buf_q, tx_buf_d;
  logic        miso_q, miso_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [5:0]  rx_nbits_q, rx_nbits_d;
  logic        rx_valid_q, rx_valid_d;

  logic        csn_fall, csn_rise, sck_rise, sck_fall;
  logic [31:0] start_word, rx_mask;

  // A csn fall only counts once csn has been seen high since reset, so a
  // transaction cut by reset is not restarted while csn is still low.
  assign csn_fall   = armed_q & csn_h_q & ~csn_s2_q;
  assign csn_rise   = csn_s2_q & ~csn_h_q;
  assign sck_rise   = sck_s2_q & ~sck_h_q;
  assign sck_fall   = ~sck_s2_q & sck_h_q;
  assign start_word = tx_load ? tx_data : tx_buf_q;
  assign rx_mask    = (cnt_q >= 6'd32) ? '1 : ((32'h1 << cnt_q) - 32'h1);

  always_comb begin
    state_d    = state_q;
    sck_s1_d   = spi_sck;
    sck_s2_d   = sck_s1_q;
    sck_h_d    = sck_s2_q;
    csn_s1_d   = spi_csn;
    csn_s2_d   = csn_s1_q;
    csn_h_d    = csn_s2_q;
    mosi_s1_d  = spi_mosi;
    mosi_s2_d  = mosi_s1_q;
    settle_d   = 1'b1;
    armed_d    = armed_q | (settle_q & csn_s1_q);
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_load ? tx_data : tx_buf_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_nbits_d = rx_nbits_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d = ACTIVE;
          cnt_d   = 6'd0;
          tx_sh_d = start_word;
          miso_d  = start_word[31];
        end
      end
      ACTIVE: begin
        if (csn_rise) begin
          state_d = IDLE;
          miso_d  = miso_idle;
          if (cnt_q != 6'd0) begin
            rx_data_d  = rx_sh_q & rx_mask;
            rx_nbits_d = cnt_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            rx_sh_d = {rx_sh_q[30:0], mosi_s2_q};
            if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
          end
          // The mode-3 leading fall arrives before any sample and must not shift.
          if (sck_fall && cnt_q != 6'd0) begin
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
            miso_d  = tx_sh_q[30];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      state_q    <= IDLE;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_h_q    <= 1'b0;
      csn_s1_q   <= 1'b1;
      csn_s2_q   <= 1'b1;
      csn_h_q    <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      settle_q   <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= 6'd0;
      rx_sh_q    <= 32'd0;
      tx_sh_q    <= 32'd0;
      tx_buf_q   <= 32'd0;
      miso_q     <= miso_idle;
      rx_data_q  <= 32'd0;
      rx_nbits_q <= 6'd0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_h_q    <= sck_h_d;
      csn_s1_q   <= csn_s1_d;
      csn_s2_q   <= csn_s2_d;
      csn_h_q    <= csn_h_d;
      mosi_s1_q  <= mosi_s1_d;
      mosi_s2_q  <= mosi_s2_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf_q   <= tx_buf_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_nbits_q <= rx_nbits_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_miso = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_nbits = rx_nbits_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: a bit-level SPI master plus a word-level model of what the
// master should read back and what rx_data/rx_nbits should report.
module tb_spi_slave;
  localparam int HALF = 80;

  logic        clk_in = 1'b0, nrst = 1'b0;
  logic        spi_sck = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso;
  logic [31:0] tx_data = 32'd0;
  logic        tx_load = 1'b0;
  logic [31:0] rx_data;
  logic [5:0]  rx_nbits;
  logic        rx_valid, busy;

  int          checks = 0, failures = 0, vcnt = 0;
  logic [31:0] m_txbuf = 32'd0, m_rx = 32'd0;

  spi_slave #(.miso_idle(1'b0)) dut (
    .clk_in(clk_in), .nrst(nrst), .spi_sck(spi_sck), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_nbits(rx_nbits), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (rx_valid) vcnt++;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Master view: first 32 bits are the tx word MSB first, zeros afterwards.
  function automatic logic [63:0] exp_miso(logic [31:0] tx, int n);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n; i++) r = {r[62:0], (i < 32) ? tx[31-i] : 1'b0};
    return r;
  endfunction

  // Slave view: the last min(n,32) bits sent, right-aligned.
  function automatic logic [31:0] exp_rx(logic [63:0] mosi_w, int n);
    int m = (n > 32) ? 32 : n;
    logic [31:0] r = mosi_w[31:0];
    if (m < 32) r = r & ((32'h1 << m) - 32'h1);
    return r;
  endfunction

  task automatic tx_write(logic [31:0] v);
    @(negedge clk_in);
    tx_data = v; tx_load = 1'b1;
    if (nrst) m_txbuf = v;
    @(negedge clk_in);
    tx_load = 1'b0;
  endtask

  task automatic spi_xfer(int mode, int n, logic [63:0] mosi_w, bit coinc, logic [31:0] cv,
                          output logic [63:0] miso_w);
    miso_w = 64'd0;
    spi_sck = (mode == 3);
    #(HALF);
    @(posedge clk_in); #1;
    spi_csn = 1'b0;
    if (coinc) begin
      // Lands tx_load on the same clk_in edge that acts on the detected csn fall.
      repeat (3) @(negedge clk_in);
      tx_data = cv; tx_load = 1'b1;
      @(negedge clk_in);
      tx_load = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (mode == 0) begin
        spi_mosi = mosi_w[n-1-i];
        #(HALF); spi_sck = 1'b1; miso_w = {miso_w[62:0], spi_miso};
        #(HALF); spi_sck = 1'b0;
      end else begin
        #(HALF); spi_sck = 1'b0; spi_mosi = mosi_w[n-1-i];
        #(HALF); spi_sck = 1'b1; miso_w = {miso_w[62:0], spi_miso};
      end
    end
    #(HALF);
    spi_csn = 1'b1;
  endtask

  task automatic run_xfer(string tag, int mode, int n, logic [63:0] mosi_w,
                          bit coinc = 1'b0, logic [31:0] cv = 32'd0);
    logic [31:0] txw;
    logic [63:0] got;
    int v0, lat;
    txw = coinc ? cv : m_txbuf;
    if (coinc) m_txbuf = cv;
    v0 = vcnt;
    spi_xfer(mode, n, mosi_w, coinc, cv, got);
    lat = 0;
    while (lat < 12 && !rx_valid) begin
      @(posedge clk_in); #1; lat++;
    end
    chk({tag, "_lat"}, (lat >= 3 && lat <= 4), 1);
    repeat (6) @(posedge clk_in);
    #1;
    chk({tag, "_miso"}, got, exp_miso(txw, n));
    m_rx = exp_rx(mosi_w, n);
    chk({tag, "_rxdata"}, rx_data, m_rx);
    chk({tag, "_nbits"}, rx_nbits, (n > 32) ? 32 : n);
    chk({tag, "_vcnt"}, vcnt - v0, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int v0;
    logic [63:0] mw;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_nbits", rx_nbits, 0);
    chk("rst_miso", spi_miso, 0);
    nrst = 1'b1;
    repeat (4) @(negedge clk_in);

    tx_write(32'hA5A5_1234);
    run_xfer("m0", 0, 32, 64'hDEAD_BEEF);
    tx_write(32'hA5A5_1234);
    run_xfer("m3", 3, 32, 64'hDEAD_BEEF);
    tx_write(32'h3300_0000);
    run_xfer("b16", 0, 16, 64'h8F00);
    tx_write(32'h9ABC_DEF0);
    run_xfer("b40", 0, 40, 64'h00C3_1234_5678_9A);

    // csn pulse with no SCK: busy rises, nothing reported
    v0 = vcnt;
    @(posedge clk_in); #1; spi_csn = 1'b0;
    repeat (6) @(posedge clk_in);
    #1; chk("nosck_busy_hi", busy, 1);
    spi_csn = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    chk("nosck_busy_lo", busy, 0);
    chk("nosck_vcnt", vcnt - v0, 0);
    chk("nosck_rxdata", rx_data, m_rx);

    // tx_load mid-transaction only affects the next one
    tx_write(32'h1357_9BDF);
    fork
      run_xfer("mid", 0, 32, {32'd0, $urandom()});
      begin #(HALF * 20); tx_write(32'h2468_ACE0); end
    join
    run_xfer("next", 3, 32, {32'd0, $urandom()});

    run_xfer("coinc", 0, 32, {32'd0, $urandom()}, 1'b1, 32'hC0DE_F00D);

    // reset after 10 bits with csn held low, tx_load during reset ignored
    tx_write(32'h1111_2222);
    v0 = vcnt;
    spi_sck = 1'b0; #(HALF);
    @(posedge clk_in); #1; spi_csn = 1'b0; #(HALF);
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom()); #(HALF); spi_sck = 1'b1; #(HALF); spi_sck = 1'b0;
    end
    chk("rst10_busy_pre", busy, 1);
    @(negedge clk_in); nrst = 1'b0;
    m_txbuf = 32'd0; m_rx = 32'd0;
    tx_write(32'hFFFF_0000);
    @(negedge clk_in);
    chk("rst10_busy", busy, 0);
    chk("rst10_miso", spi_miso, 0);
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #(HALF); spi_sck = 1'b1; #(HALF); spi_sck = 1'b0;
    end
    chk("rst10_busy_post", busy, 0);
    spi_csn = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    chk("rst10_vcnt", vcnt - v0, 0);
    chk("rst10_rxdata", rx_data, 0);
    run_xfer("after_rst", 0, 32, {32'd0, $urandom()});

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 40);
      mw = {$urandom(), $urandom()};
      if (n < 64) mw = mw & ((64'h1 << n) - 64'h1);
      tx_write($urandom());
      run_xfer("rnd", ($urandom_range(0, 1) == 0) ? 0 : 3, n, mw,
               ($urandom_range(0, 3) == 0), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
